exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter INSTRET_WIDTH, default 32, is the width of the retired-instruction counter.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 instr_valid_i  input  1  fetch stage presents a valid instruction to the decoder.
REQ-005 instr_ready_o  output  1  sequencer accepts the presented instruction this cycle.
REQ-006 jump_inst_i, branch_inst_i  input  1 each  decoder class flags (JAL/JALR, conditional branch).
REQ-007 ecall_inst_i, ebreak_inst_i, mret_inst_i, illegal_inst_i  input  1 each  decoder system/exception flags.
REQ-008 lsu_r_en_i, lsu_w_en_i  input  1 each  decoder load/store flags.
REQ-009 cmp_result_i  input  1  ALU compare bit (branch condition true).
REQ-010 lsu_done_i  input  1  LSU completes the outstanding access.
REQ-011 cycle_counter_o  output  1  instruction sub-cycle index driven to the decoder.
REQ-012 rf_we_gate_o  output  1  qualifies decoder rf_we; register file writes only when high.
REQ-013 pc_we_o  output  1  PC update strobe.
REQ-014 pc_sel_o  output  2  next-PC source: 0 PC+inc, 1 ALU result, 2 trap vector, 3 mepc.
REQ-015 lsu_req_o  output  1  LSU access request, held until done.
REQ-016 trap_o  output  1  one-cycle trap-entry pulse; CSR block saves mepc/mcause.
REQ-017 trap_cause_o  output  4  mcause code, valid while trap_o=1.
REQ-018 mret_o  output  1  one-cycle trap-return pulse to CSR block.
REQ-019 instret_o  output  INSTRET_WIDTH  retired-instruction count (only under SEQ_INSTRET_EN).

Function
REQ-020 FSM states SHALL be FETCH, EXEC, EXEC2, MEM_WAIT, TRAP; all outputs are Moore/state-decoded from state plus registered-instruction flags; unlisted outputs are 0.
REQ-021 FETCH: instr_ready_o=1; instr_valid_i=1 -> EXEC; else stay.
REQ-022 EXEC: cycle_counter_o=0; priority illegal > ebreak > ecall > mret > jump > branch > load/store > other.
REQ-023 EXEC, illegal/ebreak/ecall -> TRAP, no rf write, no pc_we.
REQ-024 EXEC, mret: pc_we_o=1, pc_sel_o=3, mret_o=1 -> FETCH.
REQ-025 EXEC, jump: rf_we_gate_o=1 (link write) -> EXEC2.
REQ-026 EXEC, branch: cmp_result_i=1 -> EXEC2; cmp_result_i=0 -> pc_we_o=1, pc_sel_o=0 -> FETCH.
REQ-027 EXEC, load/store: lsu_req_o=1 -> MEM_WAIT; lsu_done_i ignored in EXEC.
REQ-028 EXEC, other: rf_we_gate_o=1, pc_we_o=1, pc_sel_o=0 -> FETCH.
REQ-029 EXEC2: cycle_counter_o=1, pc_we_o=1, pc_sel_o=1, no rf write -> FETCH.
REQ-030 MEM_WAIT: lsu_req_o=1 until lsu_done_i; done cycle: rf_we_gate_o=lsu_r_en_i, pc_we_o=1, pc_sel_o=0 -> FETCH; no timeout.
REQ-031 TRAP: trap_o=1, pc_we_o=1, pc_sel_o=2, trap_cause_o = 2 illegal, 3 ebreak, 11 ecall -> FETCH.
REQ-032 Minimum latency: ALU op 2 cycles (FETCH+EXEC), taken branch/jump 3, load/store 3 + LSU wait cycles.
REQ-033 An instruction retires on every pc_we_o pulse outside TRAP; trapped instructions do not retire.

Reset
REQ-034 With rst=1 at a rising edge, state SHALL become FETCH and instret_o 0; all outputs except instr_ready_o are 0 in the following cycle.
REQ-035 Reset in any state, including MEM_WAIT, abandons the instruction; lsu_req_o drops the cycle after reset is sampled.

Configuration
REQ-036 SEQ_INSTRET_EN defined: instret_o present, +1 per retirement per REQ-033, wraps from all-ones to 0.
REQ-037 SEQ_INSTRET_EN undefined: instret_o port and counter absent; all other behaviour identical.

Verification
REQ-038 ADDI, instr_valid_i=1 -> EXEC: rf_we_gate_o=1, pc_we_o=1, pc_sel_o=0; back in FETCH next cycle.
REQ-039 BEQ, cmp_result_i=1 -> EXEC2: cycle_counter_o=1, pc_sel_o=1, pc_we_o=1; with cmp_result_i=0, pc_sel_o=0 in EXEC.
REQ-040 LW, lsu_done_i asserted 3 cycles after EXEC -> lsu_req_o high 4 cycles; rf_we_gate_o=1 only on the done cycle.
REQ-041 Instruction with illegal_inst_i=1 and ecall_inst_i=1 -> TRAP: trap_o=1, trap_cause_o=2, pc_sel_o=2; instret_o unchanged.
REQ-042 rst=1 during MEM_WAIT -> next cycle FETCH, lsu_req_o=0, instr_ready_o=1, instret_o=0.
REQ-043 With SEQ_INSTRET_EN, counter preset to all-ones by 2^INSTRET_WIDTH-1 ALU retirements, one more ALU op -> instret_o=0.

Source files
------------

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle instruction sequencer for a small RISC-V core.
// Walks each accepted instruction through FETCH -> EXEC [-> EXEC2 | MEM_WAIT | TRAP].
// Optional feature: define SEQ_INSTRET_EN to add the instret_o retired-instruction counter.
module exec_sequencer #(
    parameter int unsigned INSTRET_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid_i,
    output logic       instr_ready_o,
    input  logic       jump_inst_i,
    input  logic       branch_inst_i,
    input  logic       ecall_inst_i,
    input  logic       ebreak_inst_i,
    input  logic       mret_inst_i,
    input  logic       illegal_inst_i,
    input  logic       lsu_r_en_i,
    input  logic       lsu_w_en_i,
    input  logic       cmp_result_i,
    input  logic       lsu_done_i,
    output logic       cycle_counter_o,
    output logic       rf_we_gate_o,
    output logic       pc_we_o,
    output logic [1:0] pc_sel_o,
    output logic       lsu_req_o,
    output logic       trap_o,
    output logic [3:0] trap_cause_o,
    output logic       mret_o
`ifdef SEQ_INSTRET_EN
    ,
    output logic [INSTRET_WIDTH-1:0] instret_o
`endif
);

    typedef enum logic [2:0] {
        StFetch,
        StExec,
        StExec2,
        StMemWait,
        StTrap
    } state_e;

    // Decoder flags captured when the instruction is accepted.
    typedef struct packed {
        logic illegal;
        logic ebreak;
        logic ecall;
        logic mret;
        logic jump;
        logic branch;
        logic r_en;
        logic w_en;
    } flags_t;

    state_e state_d, state_q;
    flags_t flags_d, flags_q;

    // Capture decoder flags on the accepting FETCH cycle, hold them otherwise.
    always_comb begin
        flags_d = flags_q;
        if (state_q == StFetch && instr_valid_i) begin
            flags_d = '{illegal: illegal_inst_i, ebreak: ebreak_inst_i, ecall: ecall_inst_i,
                        mret: mret_inst_i, jump: jump_inst_i, branch: branch_inst_i,
                        r_en: lsu_r_en_i, w_en: lsu_w_en_i};
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_d         = state_q;
        instr_ready_o   = 1'b0;
        cycle_counter_o = 1'b0;
        rf_we_gate_o    = 1'b0;
        pc_we_o         = 1'b0;
        pc_sel_o        = 2'd0;
        lsu_req_o       = 1'b0;
        trap_o          = 1'b0;
        trap_cause_o    = 4'd0;
        mret_o          = 1'b0;
        unique case (state_q)
            StFetch: begin
                instr_ready_o = 1'b1;
                if (instr_valid_i) state_d = StExec;
            end
            StExec: begin
                if (flags_q.illegal || flags_q.ebreak || flags_q.ecall) begin
                    state_d = StTrap;
                end else if (flags_q.mret) begin
                    pc_we_o  = 1'b1;
                    pc_sel_o = 2'd3;
                    mret_o   = 1'b1;
                    state_d  = StFetch;
                end else if (flags_q.jump) begin
                    // Link register write happens here; the jump target goes out in EXEC2.
                    rf_we_gate_o = 1'b1;
                    state_d      = StExec2;
                end else if (flags_q.branch) begin
                    if (cmp_result_i) begin
                        state_d = StExec2;
                    end else begin
                        pc_we_o = 1'b1;
                        state_d = StFetch;
                    end
                end else if (flags_q.r_en || flags_q.w_en) begin
                    // lsu_done_i is deliberately ignored until MEM_WAIT.
                    lsu_req_o = 1'b1;
                    state_d   = StMemWait;
                end else begin
                    rf_we_gate_o = 1'b1;
                    pc_we_o      = 1'b1;
                    state_d      = StFetch;
                end
            end
            StExec2: begin
                cycle_counter_o = 1'b1;
                pc_we_o         = 1'b1;
                pc_sel_o        = 2'd1;
                state_d         = StFetch;
            end
            StMemWait: begin
                lsu_req_o = 1'b1;
                if (lsu_done_i) begin
                    rf_we_gate_o = flags_q.r_en;
                    pc_we_o      = 1'b1;
                    state_d      = StFetch;
                end
            end
            StTrap: begin
                trap_o   = 1'b1;
                pc_we_o  = 1'b1;
                pc_sel_o = 2'd2;
                if (flags_q.illegal) trap_cause_o = 4'd2;
                else if (flags_q.ebreak) trap_cause_o = 4'd3;
                else trap_cause_o = 4'd11;
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    // State and captured-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

`ifdef SEQ_INSTRET_EN
    logic [INSTRET_WIDTH-1:0] instret_d, instret_q;

    // Every PC update retires an instruction, except the trap-entry redirect.
    always_comb begin
        instret_d = instret_q;
        if (pc_we_o && state_q != StTrap) instret_d = instret_q + INSTRET_WIDTH'(1);
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) instret_q <= '0;
        else     instret_q <= instret_d;
    end

    assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: each instruction's expected per-cycle output
// vectors are queued when it is issued and popped as the DUT walks through it.
module tb_exec_sequencer;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic instr_valid_i = 1'b0;
    logic jump_inst_i = 1'b0, branch_inst_i = 1'b0, ecall_inst_i = 1'b0;
    logic ebreak_inst_i = 1'b0, mret_inst_i = 1'b0, illegal_inst_i = 1'b0;
    logic lsu_r_en_i = 1'b0, lsu_w_en_i = 1'b0;
    logic cmp_result_i = 1'b0, lsu_done_i = 1'b0;
    logic instr_ready_o, cycle_counter_o, rf_we_gate_o, pc_we_o, lsu_req_o, trap_o, mret_o;
    logic [1:0] pc_sel_o;
    logic [3:0] trap_cause_o;
`ifdef SEQ_INSTRET_EN
    logic [W-1:0] instret_o;
`endif

    exec_sequencer #(.INSTRET_WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .instr_valid_i   (instr_valid_i),
        .instr_ready_o   (instr_ready_o),
        .jump_inst_i     (jump_inst_i),
        .branch_inst_i   (branch_inst_i),
        .ecall_inst_i    (ecall_inst_i),
        .ebreak_inst_i   (ebreak_inst_i),
        .mret_inst_i     (mret_inst_i),
        .illegal_inst_i  (illegal_inst_i),
        .lsu_r_en_i      (lsu_r_en_i),
        .lsu_w_en_i      (lsu_w_en_i),
        .cmp_result_i    (cmp_result_i),
        .lsu_done_i      (lsu_done_i),
        .cycle_counter_o (cycle_counter_o),
        .rf_we_gate_o    (rf_we_gate_o),
        .pc_we_o         (pc_we_o),
        .pc_sel_o        (pc_sel_o),
        .lsu_req_o       (lsu_req_o),
        .trap_o          (trap_o),
        .trap_cause_o    (trap_cause_o),
        .mret_o          (mret_o)
`ifdef SEQ_INSTRET_EN
        ,
        .instret_o       (instret_o)
`endif
    );

    always #5 clk = ~clk;

    // Output vector: ready, cc, rf, pcwe, sel[1:0], req, trap, cause[3:0], mret.
    typedef struct packed {
        logic       ready;
        logic       cc;
        logic       rf;
        logic       pcwe;
        logic [1:0] sel;
        logic       req;
        logic       trap;
        logic [3:0] cause;
        logic       mret;
    } out_t;

    out_t dut_o;
    assign dut_o = {instr_ready_o, cycle_counter_o, rf_we_gate_o, pc_we_o, pc_sel_o,
                    lsu_req_o, trap_o, trap_cause_o, mret_o};

    out_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] instret_model = '0;

    // Flag vector layout: illegal, ebreak, ecall, mret, jump, branch, r_en, w_en.
    localparam logic [7:0] FAlu = 8'h00, FIll = 8'h80, FEbr = 8'h40, FEcl = 8'h20;
    localparam logic [7:0] FMret = 8'h10, FJmp = 8'h08, FBr = 8'h04, FLd = 8'h02, FSt = 8'h01;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic out_t mk(logic rdy, logic cc, logic rf, logic pcwe, logic [1:0] sel,
                                logic req, logic trap, logic [3:0] cause, logic mret);
        out_t o;
        o = '{ready: rdy, cc: cc, rf: rf, pcwe: pcwe, sel: sel, req: req, trap: trap,
              cause: cause, mret: mret};
        return o;
    endfunction

    task automatic check_instret(input string tag);
`ifdef SEQ_INSTRET_EN
        check_eq({tag, ".instret"}, 32'(instret_o), 32'(instret_model));
`endif
    endtask

    // Pop one expected vector and compare against the DUT outputs.
    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) begin
            check_eq({tag, ".queue_empty"}, 32'd0, 32'd1);
        end else begin
            check_eq(tag, 32'(dut_o), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic idle_check(input string tag);
        exp_q.push_back(mk(1, 0, 0, 0, 2'd0, 0, 0, 4'd0, 0));
        @(negedge clk);
        instr_valid_i = 1'b0;
        lsu_done_i    = 1'b0;
        #1;
        pop_check(tag);
        check_instret(tag);
    endtask

    // Issue one instruction; expected cycles are derived from its flags.
    task automatic run_instr(input string tag, input logic [7:0] fl, input logic cmp,
                             input int waits, input logic done_in_exec);
        bit is_mem = 1'b0;
        bit retire = 1'b1;
        int n;
        exp_q.push_back(mk(1, 0, 0, 0, 2'd0, 0, 0, 4'd0, 0));
        if (fl[7] || fl[6] || fl[5]) begin
            exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 0, 0, 4'd0, 0));
            exp_q.push_back(mk(0, 0, 0, 1, 2'd2, 0, 1, fl[7] ? 4'd2 : fl[6] ? 4'd3 : 4'd11, 0));
            retire = 1'b0;
        end else if (fl[4]) begin
            exp_q.push_back(mk(0, 0, 0, 1, 2'd3, 0, 0, 4'd0, 1));
        end else if (fl[3]) begin
            exp_q.push_back(mk(0, 0, 1, 0, 2'd0, 0, 0, 4'd0, 0));
            exp_q.push_back(mk(0, 1, 0, 1, 2'd1, 0, 0, 4'd0, 0));
        end else if (fl[2]) begin
            if (cmp) begin
                exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 0, 0, 4'd0, 0));
                exp_q.push_back(mk(0, 1, 0, 1, 2'd1, 0, 0, 4'd0, 0));
            end else begin
                exp_q.push_back(mk(0, 0, 0, 1, 2'd0, 0, 0, 4'd0, 0));
            end
        end else if (fl[1] || fl[0]) begin
            is_mem = 1'b1;
            exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 1, 0, 4'd0, 0));
            for (int k = 0; k < waits; k++) exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 1, 0, 4'd0, 0));
            exp_q.push_back(mk(0, 0, fl[1], 1, 2'd0, 1, 0, 4'd0, 0));
        end else begin
            exp_q.push_back(mk(0, 0, 1, 1, 2'd0, 0, 0, 4'd0, 0));
        end
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            instr_valid_i = (i == 0);
            {illegal_inst_i, ebreak_inst_i, ecall_inst_i, mret_inst_i, jump_inst_i,
             branch_inst_i, lsu_r_en_i, lsu_w_en_i} = fl;
            cmp_result_i = cmp;
            lsu_done_i   = (is_mem && i == n - 1) || (done_in_exec && i == 1);
            #1;
            pop_check($sformatf("%s.c%0d", tag, i));
            if (i == 0) check_instret(tag);
        end
        if (retire) instret_model = instret_model + 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_q.push_back(mk(1, 0, 0, 0, 2'd0, 0, 0, 4'd0, 0));
        pop_check("reset");
        check_instret("reset");
        idle_check("idle");

        run_instr("addi", FAlu, 1'b0, 0, 1'b0);
        run_instr("beq_taken", FBr, 1'b1, 0, 1'b0);
        run_instr("beq_not", FBr, 1'b0, 0, 1'b0);
        run_instr("jal", FJmp, 1'b0, 0, 1'b0);
        run_instr("lw_wait2", FLd, 1'b0, 2, 1'b0);
        run_instr("sw_done_in_exec", FSt, 1'b0, 0, 1'b1);
        run_instr("lw_nowait", FLd, 1'b0, 0, 1'b0);
        run_instr("mret", FMret, 1'b0, 0, 1'b0);
        run_instr("ill_ecall", FIll | FEcl, 1'b0, 0, 1'b0);
        run_instr("ebreak", FEbr, 1'b0, 0, 1'b0);
        run_instr("ecall", FEcl, 1'b0, 0, 1'b0);
        run_instr("ebr_ecall_mret", FEbr | FEcl | FMret, 1'b0, 0, 1'b0);
        run_instr("jmp_over_branch", FJmp | FBr | FLd, 1'b1, 0, 1'b0);
        run_instr("addi_after_trap", FAlu, 1'b0, 0, 1'b0);

        // Reset while waiting on the LSU.
        @(negedge clk);
        instr_valid_i = 1'b1;
        {illegal_inst_i, ebreak_inst_i, ecall_inst_i, mret_inst_i, jump_inst_i,
         branch_inst_i, lsu_r_en_i, lsu_w_en_i} = FLd;
        lsu_done_i = 1'b0;
        @(negedge clk);
        instr_valid_i = 1'b0;
        @(negedge clk);
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 1, 0, 4'd0, 0));
        pop_check("mem_wait_before_rst");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        instret_model = '0;
        exp_q.push_back(mk(1, 0, 0, 0, 2'd0, 0, 0, 4'd0, 0));
        pop_check("rst_in_mem_wait");
        check_instret("rst_in_mem_wait");

        // Drive the counter to all-ones, then one more retirement wraps it.
        for (int j = 0; j < (1 << W) - 1; j++) run_instr($sformatf("fill%0d", j), FAlu, 1'b0, 0, 1'b0);
        idle_check("all_ones");
        run_instr("wrap", FAlu, 1'b0, 0, 1'b0);
        idle_check("wrapped");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case a wait never completes.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
